flags_stack_unit: RTL and testbench
===================================

FLAGS_STACK_UNIT -- requirements
Module: flags_stack_unit

Interface
REQ-001 Parameter NFLAGS, default 2, SHALL set the number of flag bits (bit 0 = carry C, bit 1 = zero Z).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of save/restore stack entries (legal range 1..16).
REQ-003 One clock, clk; reset is synchronous and active-high, port name reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high clear of all state.
REQ-006 enable  input  1  flag-update strobe from the ALU path.
REQ-007 wmask  input  NFLAGS  per-flag write enable; only bits with wmask=1 update on enable.
REQ-008 flags_in  input  NFLAGS  new flag values from the ALU.
REQ-009 push  input  1  save current flags onto the stack (call/interrupt entry).
REQ-010 pop  input  1  restore flags from the top of the stack (return).
REQ-011 err_clr  input  1  clears the sticky error bits.
REQ-012 flags_out  output  NFLAGS  registered architectural flags.
REQ-013 depth_count  output  clog2(DEPTH+1)  number of occupied stack entries.
REQ-014 full / empty  output  1 each  depth_count==DEPTH / depth_count==0, combinational from the count.
REQ-015 overflow_err / underflow_err  output  1 each  sticky error flags.

Function
REQ-016 All state changes SHALL occur on the rising edge of clk; flags_out SHALL reflect a write one cycle after the strobe.
REQ-017 enable=1 with no effective pop SHALL load flags_out[i] <= flags_in[i] for each i with wmask[i]=1; bits with wmask[i]=0 SHALL hold.
REQ-018 Effective push (push=1, pop=0, not full) SHALL store the pre-edge flags_out value into entry depth_count and increment depth_count; an enable write in the same cycle SHALL still update flags_out.
REQ-019 Effective pop (pop=1, push=0, not empty) SHALL load flags_out from entry depth_count-1 and decrement depth_count; pop SHALL take priority over enable.
REQ-020 push=1 and pop=1 together SHALL leave the stack and depth_count unchanged and apply enable normally (no-op on stack, no error).
REQ-021 Push while full SHALL be ignored (no store, no count change) and SHALL set overflow_err.
REQ-022 Pop while empty SHALL be ignored (flags_out unchanged by the pop, enable applies normally) and SHALL set underflow_err.
REQ-023 overflow_err and underflow_err SHALL hold once set until err_clr or reset; a set event in the same cycle as err_clr SHALL win (error remains set).
REQ-024 depth_count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-025 reset=1 at a rising edge SHALL clear flags_out, depth_count, overflow_err and underflow_err to 0; full SHALL read 0 and empty SHALL read 1.
REQ-026 reset SHALL override enable, push, pop and err_clr in the same cycle, including mid-sequence with a partially filled stack.
REQ-027 Stack entry contents SHALL need no reset; an entry SHALL be readable only after it has been pushed.

Structure
REQ-028 A shared package SHALL hold flag index constants FLAG_C=0 and FLAG_Z=1 and the default NFLAGS/DEPTH values.
REQ-029 Stack storage and pointer SHALL be one sub-module, flags_lifo (parameters NFLAGS, DEPTH; ports: push, pop, wdata, rdata, count); flag register and error logic SHALL stay in the top.

Verification
REQ-030 Reset, then enable=1, wmask=2'b11, flags_in=2'b01 -> flags_out=2'b01 next cycle; then wmask=2'b10, flags_in=2'b10 -> flags_out=2'b11.
REQ-031 flags_out=2'b11, push=1 with enable=1, flags_in=2'b00 -> depth_count=1, flags_out=2'b00; pop -> flags_out=2'b11, depth_count=0.
REQ-032 DEPTH=4: push five times with distinct values -> full=1 after the fourth, overflow_err=1 after the fifth, depth_count=4; four pops return values in LIFO order.
REQ-033 Empty stack, pop=1 with enable=1, flags_in=2'b10 -> underflow_err=1, flags_out=2'b10; err_clr -> underflow_err=0.
REQ-034 depth_count=2, push=1 and pop=1 together -> depth_count=2, no error; then reset -> flags_out=0, depth_count=0, empty=1.

Source files
------------

// File: rtl/flags_stack_unit_pkg.sv
// Shared definitions for the flags stack unit.
//   FLAG_C / FLAG_Z  : bit positions of carry and zero inside the flag vector
//   DEFAULT_NFLAGS   : default flag vector width
//   DEFAULT_DEPTH    : default number of save/restore stack entries
//   stack_op_e       : decoded stack operation for the current cycle
package flags_stack_unit_pkg;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;

  localparam int unsigned DEFAULT_NFLAGS = 2;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } stack_op_e;

endpackage

// File: rtl/flags_stack_unit_if.sv
// Flag/stack control bundle between the ALU path (master) and the flags
// stack unit (slave).
//   enable, wmask, flags_in    : flag update strobe, per-flag write enable, data
//   push, pop, err_clr         : stack save/restore requests, sticky error clear
//   flags_out, depth_count     : architectural flags, occupied stack entries
//   full, empty                : stack occupancy status
//   overflow_err, underflow_err: sticky error flags
interface flags_stack_unit_if
  import flags_stack_unit_pkg::*;
#(
  parameter int unsigned NFLAGS = DEFAULT_NFLAGS,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              enable;
  logic [NFLAGS-1:0] wmask;
  logic [NFLAGS-1:0] flags_in;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] flags_out;
  logic [CW-1:0]     depth_count;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output enable, wmask, flags_in, push, pop, err_clr,
    input  flags_out, depth_count, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  enable, wmask, flags_in, push, pop, err_clr,
    output flags_out, depth_count, full, empty, overflow_err, underflow_err
  );

endinterface

// File: rtl/flags_stack_unit_lifo.sv
// flags_lifo: save/restore storage for flag vectors with occupancy pointer.
//   clk, reset : clock, synchronous active-high clear of the pointer
//   push       : store wdata into entry count, increment count
//   pop        : decrement count
//   wdata      : flag vector to save
//   rdata      : entry count-1 (top of stack), '0 when empty
//   count      : number of occupied entries
// push/pop arrive already qualified (never both, never push when full,
// never pop when empty); entries themselves are not reset.
module flags_lifo
  import flags_stack_unit_pkg::*;
#(
  parameter int unsigned NFLAGS = DEFAULT_NFLAGS,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [NFLAGS-1:0]            wdata,
  output logic [NFLAGS-1:0]            rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] mem [DEPTH];

  // Entry selection is done by comparing against the count rather than
  // indexing with it, since count is one bit wider than an entry index.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && count == CW'(i)) begin
        mem[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (push) begin
      count <= count + CW'(1);
    end else if (pop) begin
      count <= count - CW'(1);
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (count == CW'(i + 1)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/flags_stack_unit.sv
// flags_stack_unit: architectural flag register with a save/restore stack.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear of flags, stack pointer and errors
//   bus   : slave side of flags_stack_unit_if (update/push/pop/err_clr in;
//           flags_out, depth_count, full, empty, sticky errors out)
module flags_stack_unit
  import flags_stack_unit_pkg::*;
#(
  parameter int unsigned NFLAGS = DEFAULT_NFLAGS,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  flags_stack_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] flags;
  logic [NFLAGS-1:0] top_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;
  stack_op_e         op;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // push together with pop is a stack no-op and raises no error.
  always_comb begin
    op = OP_NONE;
    if (bus.push && !bus.pop) begin
      op = full ? OP_OVERFLOW : OP_PUSH;
    end else if (bus.pop && !bus.push) begin
      op = empty ? OP_UNDERFLOW : OP_POP;
    end
  end

  flags_lifo #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (op == OP_PUSH),
    .pop   (op == OP_POP),
    .wdata (flags),
    .rdata (top_data),
    .count (count)
  );

  // A real pop restores the saved flags and overrides any ALU update.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (op == OP_POP) begin
      flags <= top_data;
    end else if (bus.enable) begin
      flags <= (flags & ~bus.wmask) | (bus.flags_in & bus.wmask);
    end
  end

  // Setting wins over clearing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (op == OP_OVERFLOW)  || (ovf && !bus.err_clr);
      unf <= (op == OP_UNDERFLOW) || (unf && !bus.err_clr);
    end
  end

  assign bus.flags_out     = flags;
  assign bus.depth_count   = count;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.overflow_err  = ovf;
  assign bus.underflow_err = unf;

endmodule

// File: tb/tb_flags_stack_unit.sv
// Directed bench for flags_stack_unit (NFLAGS=2, DEPTH=4). Each stimulus
// cycle queues the hand-computed post-edge state; a monitor pops and
// compares one entry after every rising edge.
module tb_flags_stack_unit;

  typedef struct {
    string      name;
    logic [1:0] flags;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  flags_stack_unit_if #(.NFLAGS(2), .DEPTH(4)) bus ();

  flags_stack_unit #(.NFLAGS(2), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "flags_out",     32'(bus.flags_out),     32'(e.flags));
        chk(e.name, "depth_count",   32'(bus.depth_count),   32'(e.cnt));
        chk(e.name, "full",          32'(bus.full),          32'(e.full));
        chk(e.name, "empty",         32'(bus.empty),         32'(e.empty));
        chk(e.name, "overflow_err",  32'(bus.overflow_err),  32'(e.ovf));
        chk(e.name, "underflow_err", 32'(bus.underflow_err), 32'(e.unf));
      end
    end
  end

  // Drive one cycle of stimulus at the falling edge and queue the state
  // expected after the following rising edge.
  task automatic step(input string name, input logic rst, input logic en,
                      input logic [1:0] wm, input logic [1:0] fin,
                      input logic pu, input logic po, input logic ec,
                      input logic [1:0] ef, input logic [2:0] ecnt,
                      input logic efull, input logic eempty,
                      input logic eovf, input logic eunf);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.enable   = en;
    bus.wmask    = wm;
    bus.flags_in = fin;
    bus.push     = pu;
    bus.pop      = po;
    bus.err_clr  = ec;
    e.name  = name;
    e.flags = ef;
    e.cnt   = ecnt;
    e.full  = efull;
    e.empty = eempty;
    e.ovf   = eovf;
    e.unf   = eunf;
    q.push_back(e);
  endtask

  initial begin : stimulus
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.wmask    = '0;
    bus.flags_in = '0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.err_clr  = 1'b0;

    //    name          rst en  wm     fin    pu po ec  flags  cnt  fu em ov un
    step("reset",       1, 0, 2'b00, 2'b00, 0, 0, 0,  2'b00, 3'd0, 0, 1, 0, 0);
    step("wr_all",      0, 1, 2'b11, 2'b01, 0, 0, 0,  2'b01, 3'd0, 0, 1, 0, 0);
    step("wr_z_only",   0, 1, 2'b10, 2'b10, 0, 0, 0,  2'b11, 3'd0, 0, 1, 0, 0);
    step("push_wr",     0, 1, 2'b11, 2'b00, 1, 0, 0,  2'b00, 3'd1, 0, 0, 0, 0);
    step("pop_back",    0, 0, 2'b00, 2'b00, 0, 1, 0,  2'b11, 3'd0, 0, 1, 0, 0);

    // Five pushes, each saving the current flags and loading a new value.
    step("fill1",       0, 1, 2'b11, 2'b00, 1, 0, 0,  2'b00, 3'd1, 0, 0, 0, 0);
    step("fill2",       0, 1, 2'b11, 2'b01, 1, 0, 0,  2'b01, 3'd2, 0, 0, 0, 0);
    step("fill3",       0, 1, 2'b11, 2'b10, 1, 0, 0,  2'b10, 3'd3, 0, 0, 0, 0);
    step("fill4_full",  0, 1, 2'b11, 2'b11, 1, 0, 0,  2'b11, 3'd4, 1, 0, 0, 0);
    step("push_ovf",    0, 1, 2'b11, 2'b00, 1, 0, 0,  2'b00, 3'd4, 1, 0, 1, 0);
    step("lifo1",       0, 1, 2'b11, 2'b01, 0, 1, 0,  2'b10, 3'd3, 0, 0, 1, 0);
    step("lifo2",       0, 0, 2'b00, 2'b00, 0, 1, 0,  2'b01, 3'd2, 0, 0, 1, 0);
    step("lifo3",       0, 0, 2'b00, 2'b00, 0, 1, 0,  2'b00, 3'd1, 0, 0, 1, 0);
    step("lifo4",       0, 0, 2'b00, 2'b00, 0, 1, 0,  2'b11, 3'd0, 0, 1, 1, 0);
    step("ovf_clr",     0, 0, 2'b00, 2'b00, 0, 0, 1,  2'b11, 3'd0, 0, 1, 0, 0);

    step("pop_unf",     0, 1, 2'b11, 2'b10, 0, 1, 0,  2'b10, 3'd0, 0, 1, 0, 1);
    step("unf_clr",     0, 0, 2'b00, 2'b00, 0, 0, 1,  2'b10, 3'd0, 0, 1, 0, 0);
    step("unf_set_clr", 0, 0, 2'b00, 2'b00, 0, 1, 1,  2'b10, 3'd0, 0, 1, 0, 1);
    step("unf_clr2",    0, 0, 2'b00, 2'b00, 0, 0, 1,  2'b10, 3'd0, 0, 1, 0, 0);
    step("wr_c_only",   0, 1, 2'b01, 2'b01, 0, 0, 0,  2'b11, 3'd0, 0, 1, 0, 0);

    step("push_a",      0, 0, 2'b00, 2'b00, 1, 0, 0,  2'b11, 3'd1, 0, 0, 0, 0);
    step("push_b",      0, 1, 2'b11, 2'b01, 1, 0, 0,  2'b01, 3'd2, 0, 0, 0, 0);
    step("push_pop",    0, 1, 2'b11, 2'b10, 1, 1, 0,  2'b10, 3'd2, 0, 0, 0, 0);
    step("pop_prio",    0, 1, 2'b11, 2'b00, 0, 1, 0,  2'b11, 3'd1, 0, 0, 0, 0);
    step("reset_mid",   1, 1, 2'b11, 2'b01, 1, 0, 1,  2'b00, 3'd0, 0, 1, 0, 0);
    step("pop_after_r", 0, 0, 2'b00, 2'b00, 0, 1, 0,  2'b00, 3'd0, 0, 1, 0, 1);
    step("idle",        0, 0, 2'b00, 2'b00, 0, 0, 0,  2'b00, 3'd0, 0, 1, 0, 1);

    @(negedge clk);
    bus.pop = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
